// File: rtl/line_draw.sv
// Bresenham line rasteriser covering all eight octants.
// Streams one pixel write per valid/ready handshake.
module line_draw #(
    parameter int COORD_W = 10,
    parameter int COLOR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [COLOR_W-1:0] pix_color
);

    localparam int EW = COORD_W + 3;
    localparam logic signed [EW-1:0] ZERO = '0;
    localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

    typedef enum logic [1:0] {IDLE, SETUP, DRAW, FIN} state_t;

    state_t state, state_nxt;

    logic [COORD_W-1:0] ex0, ey0, ex1, ey1;
    logic [COORD_W-1:0] cx, cy;
    logic [COLOR_W-1:0] col_q;
    logic               xneg, yneg;

    logic signed [EW-1:0] dx, dy, err;
    logic signed [EW-1:0] adx, ady, e2, err_nxt;
    logic [COORD_W-1:0]   xd, yd;
    logic                 hs, at_end, step_x, step_y;

    // Setup magnitudes are taken from the latched endpoints.
    always_comb begin
        xd  = (ex1 >= ex0) ? ex1 - ex0 : ex0 - ex1;
        yd  = (ey1 >= ey0) ? ey1 - ey0 : ey0 - ey1;
        adx = $signed({3'b000, xd});
        ady = $signed({3'b000, yd});
    end

    always_comb begin
        hs      = (state == DRAW) && pix_ready;
        at_end  = (cx == ex1) && (cy == ey1);
        e2      = err <<< 1;
        step_x  = (e2 >= dy);
        step_y  = (e2 <= dx);
        err_nxt = err + (step_x ? dy : ZERO) + (step_y ? dx : ZERO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start)
                    state_nxt = SETUP;
            end
            SETUP: begin
                if (abort)
                    state_nxt = IDLE;
                else
                    state_nxt = DRAW;
            end
            DRAW: begin
                if (abort)
                    state_nxt = IDLE;
                else if (hs && at_end)
                    state_nxt = FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex0   <= '0;
            ey0   <= '0;
            ex1   <= '0;
            ey1   <= '0;
            col_q <= '0;
            cx    <= '0;
            cy    <= '0;
            xneg  <= 1'b0;
            yneg  <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            err   <= '0;
        end else begin
            if (state == IDLE && start) begin
                ex0   <= x0;
                ey0   <= y0;
                ex1   <= x1;
                ey1   <= y1;
                col_q <= color;
            end
            if (state == SETUP) begin
                dx   <= adx;
                dy   <= -ady;
                err  <= adx - ady;
                xneg <= (ex1 < ex0);
                yneg <= (ey1 < ey0);
                cx   <= ex0;
                cy   <= ey0;
            end
            // Advance only once the current point has been accepted.
            if (hs && !at_end) begin
                err <= err_nxt;
                if (step_x)
                    cx <= xneg ? cx - ONE : cx + ONE;
                if (step_y)
                    cy <= yneg ? cy - ONE : cy + ONE;
            end
        end
    end

    always_comb begin
        busy      = (state != IDLE);
        done      = (state == FIN);
        pix_valid = (state == DRAW);
        pix_x     = cx;
        pix_y     = cy;
        pix_color = col_q;
    end

endmodule

// File: tb/tb_line_draw.sv
// Scoreboard bench for line_draw: directed lines with
// hand-computed pixel sequences, backpressure, abort and reset.
module tb_line_draw;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [9:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
    logic [7:0] color = '0;
    logic       busy, done, pix_valid;
    logic       pix_ready = 1'b1;
    logic [9:0] pix_x, pix_y;
    logic [7:0] pix_color;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] c;
    } pix_t;

    pix_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   hs_cnt = 0;
    int   done_cnt = 0;
    int   ready_mode = 0;
    int   rc = 0;

    line_draw #(.COORD_W(10), .COLOR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .x0(x0), .y0(y0), .x1(x1), .y1(y1), .color(color),
        .busy(busy), .done(done), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_color(pix_color)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int x, input int y, input logic [7:0] c);
        pix_t p;
        p.x = x[9:0];
        p.y = y[9:0];
        p.c = c;
        sb.push_back(p);
    endtask

    // Ready pattern 1,0,0,1 repeating when backpressure is enabled.
    initial forever begin
        @(posedge clk);
        #2;
        rc++;
        if (ready_mode != 0)
            pix_ready = (rc % 4 == 0) || (rc % 4 == 3);
        else
            pix_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on every handshake.
    initial begin
        logic prev_stall;
        pix_t prev, e;
        prev_stall = 1'b0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
                continue;
            end
            if (prev_stall)
                chk("stall_hold", {pix_valid, pix_x, pix_y, pix_color},
                    {1'b1, prev.x, prev.y, prev.c});
            if (done) begin
                done_cnt++;
                chk("done_no_valid", pix_valid, 1'b0);
            end
            if (pix_valid && pix_ready) begin
                hs_cnt++;
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_pixel: got (%0d,%0d) expected none",
                             pix_x, pix_y);
                end else begin
                    e = sb.pop_front();
                    chk("pixel", {pix_x, pix_y, pix_color}, {e.x, e.y, e.c});
                end
            end
            prev_stall = pix_valid && !pix_ready;
            prev = {pix_x, pix_y, pix_color};
        end
    end

    task automatic launch(input int a, input int b, input int c,
                          input int d, input logic [7:0] col);
        @(negedge clk);
        x0 = a[9:0];
        y0 = b[9:0];
        x1 = c[9:0];
        y1 = d[9:0];
        color = col;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("lat_busy", busy, 1'b1);
        chk("lat_no_valid", pix_valid, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_valid", pix_valid, 1'b1);
    endtask

    task automatic wait_idle(input int budget, input int done_exp);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_reached", busy, 1'b0);
        chk("sb_empty", sb.size(), 0);
        chk("done_count", done_cnt, done_exp);
    endtask

    initial begin
        int n, hs0, dexp;
        dexp = 0;
        #12;
        chk("rst_outputs", {busy, done, pix_valid, pix_x, pix_y, pix_color}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Horizontal line
        for (int i = 2; i <= 9; i++) push(i, 5, 8'h11);
        launch(2, 5, 9, 5, 8'h11);
        dexp++;
        wait_idle(100, dexp);

        // Steep reverse line
        for (int y = 20; y >= 2; y--)
            push((y >= 18) ? 10 : (y >= 12) ? 9 : (y >= 6) ? 8 : 7, y, 8'h22);
        launch(10, 20, 7, 2, 8'h22);
        dexp++;
        wait_idle(100, dexp);

        // Single point
        push(0, 0, 8'hA5);
        launch(0, 0, 0, 0, 8'hA5);
        dexp++;
        wait_idle(20, dexp);

        // Backpressure
        ready_mode = 1;
        push(0, 0, 8'h33);
        push(1, 1, 8'h33);
        push(2, 1, 8'h33);
        push(3, 2, 8'h33);
        push(4, 2, 8'h33);
        hs0 = hs_cnt;
        launch(0, 0, 4, 2, 8'h33);
        dexp++;
        wait_idle(100, dexp);
        chk("bp_count", hs_cnt - hs0, 5);
        ready_mode = 0;
        @(posedge clk);
        #3;

        // Abort after 10 handshakes
        push(0, 0, 8'h44); push(1, 1, 8'h44); push(2, 1, 8'h44);
        push(3, 2, 8'h44); push(4, 3, 8'h44); push(5, 4, 8'h44);
        push(6, 4, 8'h44); push(7, 5, 8'h44); push(8, 6, 8'h44);
        push(9, 7, 8'h44);
        hs0 = hs_cnt;
        launch(0, 0, 639, 479, 8'h44);
        n = 0;
        while (hs_cnt < hs0 + 9 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_valid", pix_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        @(posedge clk);
        #1;
        chk("abort_hs", hs_cnt - hs0, 10);
        wait_idle(5, dexp);

        for (int i = 1; i <= 3; i++) push(i, 1, 8'h55);
        launch(1, 1, 3, 1, 8'h55);
        dexp++;
        wait_idle(50, dexp);

        // Start while busy, then full-screen diagonal
        for (int i = 0; i < 1024; i++) push(i, i, 8'h66);
        launch(0, 0, 1023, 1023, 8'h66);
        @(negedge clk);
        x0 = 10'd5;
        y0 = 10'd5;
        x1 = 10'd6;
        y1 = 10'd6;
        color = 8'h77;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dexp++;
        wait_idle(1100, dexp);

        // Reset mid-line
        for (int i = 0; i <= 20; i++) push(i, 0, 8'h88);
        launch(0, 0, 20, 0, 8'h88);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs",
            {busy, done, pix_valid, pix_x, pix_y, pix_color}, '0);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_idle", busy, 1'b0);
        chk("midrst_no_done", done_cnt, dexp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
